// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: turns a push-button request into a tick-aligned output pulse of HIGH_TICKS ticks
// Ports:
//   clk    - system clock, all state updates on posedge
//   reset  - synchronous, active-low reset
//   en     - prescaler enable; 0 freezes the prescaler, so no ticks occur
//   b      - button request, active-high, asynchronous to clk
//   x      - output pulse, high only in ACTIVE
//   busy   - high whenever the FSM is not IDLE
//   done   - one-cycle pulse on entry to RELEASE
//   state  - current FSM state encoding (IDLE=00, WAIT_TICK=01, ACTIVE=10, RELEASE=11)
module pulse_seq_ctrl #(
    parameter int TICK_BITS  = 25,
    parameter int CNT_W      = 8,
    parameter int HIGH_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       b,
    output logic       x,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);
    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] WAIT_TICK = 2'b01;
    localparam logic [1:0] ACTIVE    = 2'b10;
    localparam logic [1:0] RELEASE   = 2'b11;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HIGH_TICKS - 1);

    logic                 b_s1_q, b_s2_q, b_prev_q;
    logic [TICK_BITS-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           state_q, state_d;
    logic                 done_q, done_d;
    logic                 rise, tick;

    assign rise    = b_s2_q & ~b_prev_q;
    assign tick    = en & (&presc_q);
    assign presc_d = en ? presc_q + TICK_BITS'(1) : presc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:      state_d = rise ? WAIT_TICK : IDLE;
            WAIT_TICK: begin
                // Pulse start is aligned to a tick boundary
                if (tick) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (tick) begin
                    if (cnt_q == LAST) begin
                        state_d = RELEASE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default:   state_d = b_s2_q ? RELEASE : IDLE; // wait for button release so a held press never retriggers
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            b_s1_q   <= 1'b0;
            b_s2_q   <= 1'b0;
            b_prev_q <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            done_q   <= 1'b0;
        end else begin
            b_s1_q   <= b;
            b_s2_q   <= b_s1_q;
            b_prev_q <= b_s2_q;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            done_q   <= done_d;
        end
    end

    assign x     = (state_q == ACTIVE);
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign state = state_q;
endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb_pulse_seq_ctrl: directed bench for pulse_seq_ctrl with TICK_BITS=3, HIGH_TICKS=3
module tb_pulse_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset, en, b;
    logic       x, busy, done;
    logic [1:0] state;
    int         total = 0, bad = 0;
    int         nx, nd, nxr, nrel;
    logic       px;
    logic [31:0] p0;

    pulse_seq_ctrl #(.TICK_BITS(3), .CNT_W(8), .HIGH_TICKS(3)) dut (
        .clk(clk), .reset(reset), .en(en), .b(b),
        .x(x), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        nx = 0; nd = 0; nxr = 0; nrel = 0; px = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (x === 1'b1) nx++;
        if (done === 1'b1) nd++;
        if (state === 2'b11) nrel++;
        if (x === 1'b1 && px !== 1'b1) nxr++;
        px = x;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic until_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            step();
            if (busy === 1'b0) break;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic until_x(input string tag);
        for (int i = 0; i < 60; i++) begin
            step();
            if (x === 1'b1) break;
        end
        check(tag, {31'd0, x}, 32'd1);
    endtask

    task automatic press(input int n);
        b = 1'b1;
        steps(n);
        b = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; b = 1'b0;
        clr();
        // 1. reset with b toggling
        for (int i = 0; i < 3; i++) begin
            b = ~b;
            step();
            check("rst_x", {31'd0, x}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_state", {30'd0, state}, 32'd0);
        end
        b = 1'b0;
        reset = 1'b1;
        check("rst_presc", 32'(dut.presc_q), 32'd0);
        steps(5);
        check("idle_state", {30'd0, state}, 32'd0);

        // 2. short press
        clr();
        b = 1'b1;
        steps(3);
        check("short_wait", {30'd0, state}, 32'd1);
        step();
        b = 1'b0;
        until_idle("short_to");
        check("short_x24", nx, 32'd24);
        check("short_done1", nd, 32'd1);
        check("short_xrise", nxr, 32'd1);
        check("short_rel1", nrel, 32'd1);
        check("short_state", {30'd0, state}, 32'd0);

        // 3. held press
        clr();
        press(100);
        check("held_rel", {30'd0, state}, 32'd3);
        check("held_done0", {31'd0, done}, 32'd0);
        step();
        check("held_lag1", {30'd0, state}, 32'd3);
        step();
        check("held_lag2", {30'd0, state}, 32'd3);
        step();
        check("held_idle", {30'd0, state}, 32'd0);
        check("held_x24", nx, 32'd24);
        check("held_done1", nd, 32'd1);
        check("held_xrise", nxr, 32'd1);

        // 4. re-press during ACTIVE
        steps(3);
        clr();
        press(4);
        until_x("rep_x_to");
        steps(9);
        press(4);
        until_idle("rep_to");
        steps(40);
        check("rep_x24", nx, 32'd24);
        check("rep_done1", nd, 32'd1);
        check("rep_xrise", nxr, 32'd1);
        check("rep_idle", {30'd0, state}, 32'd0);

        // 5. reset mid-ACTIVE
        clr();
        press(4);
        until_x("rma_x_to");
        steps(11);
        check("rma_x12", nx, 32'd12);
        reset = 1'b0;
        step();
        check("rma_x0", {31'd0, x}, 32'd0);
        check("rma_state", {30'd0, state}, 32'd0);
        check("rma_done0", {31'd0, done}, 32'd0);
        reset = 1'b1;
        steps(30);
        check("rma_nd0", nd, 32'd0);
        check("rma_idle", {30'd0, state}, 32'd0);
        clr();
        press(4);
        until_idle("rma2_to");
        check("rma2_x24", nx, 32'd24);
        check("rma2_done1", nd, 32'd1);

        // 6. en=0 for 20 cycles mid-ACTIVE
        steps(3);
        clr();
        press(4);
        until_x("en_x_to");
        steps(5);
        en = 1'b0;
        p0 = 32'(dut.presc_q);
        steps(20);
        check("en_frozen", 32'(dut.presc_q), p0);
        check("en_x_held", {31'd0, x}, 32'd1);
        en = 1'b1;
        until_idle("en_to");
        check("en_x44", nx, 32'd44);
        check("en_done1", nd, 32'd1);
        check("en_xrise", nxr, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
